// File: rtl/nexys4_input_debouncer.sv
// Synchroniser + per-bit debouncer for Nexys4-DDR switches and buttons, with edge strobes.
// Optional sticky press flags are built when NEXYS4_INPUT_STICKY_EN is defined.
module nexys4_input_debouncer #(
  parameter int unsigned N_SW            = 16,
  parameter int unsigned N_PB            = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic            SI_ClkIn,
  input  logic            SI_Reset_N,
  input  logic [N_SW-1:0] SW_raw,
  input  logic [N_PB-1:0] PB_raw,
  output logic [N_SW-1:0] SW_db,
  output logic [N_PB-1:0] PB_db,
  output logic [N_PB-1:0] PB_press,
  output logic [N_PB-1:0] PB_release,
  output logic            SW_chg,
  input  logic [N_PB-1:0] PB_clr,
  output logic [N_PB-1:0] PB_sticky
);

  localparam int unsigned N = N_SW + N_PB;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Switches occupy the low bits, buttons the high bits of every per-bit vector.
  logic [N-1:0]     raw;
  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [N-1:0]     stb;
  logic [N-1:0]     stb_nxt;
  logic [CNT_W-1:0] cnt     [N];
  logic [CNT_W-1:0] cnt_nxt [N];

  assign raw = {PB_raw, SW_raw};

  // Count consecutive mismatches; commit the new level once the run reaches the threshold.
  always_comb begin
    stb_nxt = stb;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stb[i]) begin
        if (cnt[i] == CNT_TERM) begin
          stb_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      sync1      <= '0;
      sync2      <= '0;
      stb        <= '0;
      PB_press   <= '0;
      PB_release <= '0;
      SW_chg     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      stb        <= stb_nxt;
      // Strobes are registered from the next-state so they line up with the db change.
      PB_press   <= stb_nxt[N-1:N_SW] & ~stb[N-1:N_SW];
      PB_release <= ~stb_nxt[N-1:N_SW] & stb[N-1:N_SW];
      SW_chg     <= |(stb_nxt[N_SW-1:0] ^ stb[N_SW-1:0]);
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign SW_db = stb[N_SW-1:0];
  assign PB_db = stb[N-1:N_SW];

`ifdef NEXYS4_INPUT_STICKY_EN
  // Set has priority over clear so a press coinciding with a clear is not lost.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      PB_sticky <= '0;
    end else begin
      PB_sticky <= (PB_sticky & ~PB_clr) | PB_press;
    end
  end
`else
  logic [N_PB-1:0] pb_clr_unused;
  assign pb_clr_unused = PB_clr;
  assign PB_sticky     = '0;
`endif

endmodule

// File: tb/tb_nexys4_input_debouncer.sv
// Self-checking bench for nexys4_input_debouncer: directed scenarios plus randomized bounce
// traffic checked against a sliding-window reference model.
module tb_nexys4_input_debouncer;

  localparam int unsigned N_SW  = 16;
  localparam int unsigned N_PB  = 5;
  localparam int unsigned D     = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned NB    = N_SW + N_PB;
  localparam int unsigned GW    = N_SW + 4 * N_PB + 1;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic [N_SW-1:0] sw_raw = '0;
  logic [N_PB-1:0] pb_raw = '0;
  logic [N_PB-1:0] pb_clr = '0;
  logic [N_SW-1:0] SW_db;
  logic [N_PB-1:0] PB_db;
  logic [N_PB-1:0] PB_press;
  logic [N_PB-1:0] PB_release;
  logic            SW_chg;
  logic [N_PB-1:0] PB_sticky;

  int checks   = 0;
  int failures = 0;

  nexys4_input_debouncer #(
    .N_SW(N_SW), .N_PB(N_PB), .DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)
  ) dut (
    .SI_ClkIn(clk), .SI_Reset_N(rst_n), .SW_raw(sw_raw), .PB_raw(pb_raw),
    .SW_db(SW_db), .PB_db(PB_db), .PB_press(PB_press), .PB_release(PB_release),
    .SW_chg(SW_chg), .PB_clr(pb_clr), .PB_sticky(PB_sticky)
  );

  always #5 clk = ~clk;

  logic [GW-1:0] got;
  assign got = {SW_db, PB_db, PB_press, PB_release, SW_chg, PB_sticky};

  // Reference model: a level is committed once the last D synchronised samples all
  // disagree with the current output. hist[b][j] holds the raw sample from j edges ago.
  bit              hist [NB][D+1];
  logic [NB-1:0]   m_db;
  logic [N_PB-1:0] m_press, m_rel, m_sticky;
  logic            m_chg;

  function automatic logic [GW-1:0] exp_vec();
    return {m_db[N_SW-1:0], m_db[NB-1:N_SW], m_press, m_rel, m_chg, m_sticky};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int j = 0; j <= D; j++) hist[b][j] = 1'b0;
    m_db = '0; m_press = '0; m_rel = '0; m_chg = 1'b0; m_sticky = '0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] raw_now;
    logic [NB-1:0] nd;
    logic          all_diff;
    raw_now = {pb_raw, sw_raw};
    nd      = m_db;
    for (int b = 0; b < NB; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) if (hist[b][j] == m_db[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_db[b];
    end
`ifdef NEXYS4_INPUT_STICKY_EN
    m_sticky = (m_sticky & ~pb_clr) | m_press;
`else
    m_sticky = '0;
`endif
    m_press = nd[NB-1:N_SW] & ~m_db[NB-1:N_SW];
    m_rel   = ~nd[NB-1:N_SW] & m_db[NB-1:N_SW];
    m_chg   = |(nd[N_SW-1:0] ^ m_db[N_SW-1:0]);
    m_db    = nd;
    for (int b = 0; b < NB; b++) begin
      for (int j = D; j >= 1; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = raw_now[b];
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    sw_raw = 16'hA5C3; pb_raw = 5'b10110; pb_clr = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (got !== '0) begin
        failures++; $display("FAIL reset_hold cyc=%0d got=%h exp=0", c, got);
      end
      checks++;
    end
    sw_raw = '0; pb_raw = '0; pb_clr = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (got !== '0) begin
        failures++; $display("FAIL reset_quiet cyc=%0d got=%h exp=0", c, got);
      end
      checks++;
    end
  endtask

  task automatic test_press_latency();
    pb_raw[2] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (got !== exp_vec()) begin
        failures++; $display("FAIL press_model edge=%0d got=%h exp=%h", e, got, exp_vec());
      end
      checks++;
      if (e == 5 && PB_db !== 5'b00000) begin
        failures++; $display("FAIL press_early edge=%0d PB_db=%b exp=00000", e, PB_db);
      end
      if (e == 6 && {PB_db, PB_press} !== {5'b00100, 5'b00100}) begin
        failures++; $display("FAIL press_edge6 db=%b press=%b exp=00100/00100", PB_db, PB_press);
      end
      if (e == 7 && {PB_db, PB_press} !== {5'b00100, 5'b00000}) begin
        failures++; $display("FAIL press_edge7 db=%b press=%b exp=00100/00000", PB_db, PB_press);
      end
      if (e >= 5) checks++;
    end
    pb_raw[2] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (got !== exp_vec()) begin
        failures++; $display("FAIL release_model edge=%0d got=%h exp=%h", e, got, exp_vec());
      end
      checks++;
      if (e == 6 && PB_release !== 5'b00100) begin
        failures++; $display("FAIL release_edge6 rel=%b exp=00100", PB_release);
      end
      if (e == 6) checks++;
    end
  endtask

  task automatic test_sw_bounce();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      sw_raw[0] = ~k[0];
      for (int c = 0; c < 2; c++) begin
        tick();
        if (SW_chg !== 1'b0 || SW_db[0] !== 1'b0) begin
          failures++; $display("FAIL bounce_quiet k=%0d chg=%b db=%b exp=0/0", k, SW_chg, SW_db[0]);
        end
        checks++;
      end
    end
    sw_raw[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (got !== exp_vec()) begin
        failures++; $display("FAIL bounce_model edge=%0d got=%h exp=%h", e, got, exp_vec());
      end
      checks++;
      if (SW_chg === 1'b1) pulses++;
      if (e == 6 && {SW_db[0], SW_chg} !== 2'b11) begin
        failures++; $display("FAIL bounce_edge6 db=%b chg=%b exp=1/1", SW_db[0], SW_chg);
      end
      if (e == 6) checks++;
    end
    if (pulses != 1) begin
      failures++; $display("FAIL bounce_pulses got=%0d exp=1", pulses);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    int pulses;
    pulses = 0;
    sw_raw[3] = 1'b1; sw_raw[9] = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (got !== exp_vec()) begin
        failures++; $display("FAIL simul_model edge=%0d got=%h exp=%h", e, got, exp_vec());
      end
      checks++;
      if (SW_chg === 1'b1) pulses++;
      if (SW_db[3] !== SW_db[9]) begin
        failures++; $display("FAIL simul_split edge=%0d sw3=%b sw9=%b", e, SW_db[3], SW_db[9]);
      end
      checks++;
    end
    if (pulses != 1 || SW_db[9] !== 1'b1) begin
      failures++; $display("FAIL simul_pulses got=%0d/%b exp=1/1", pulses, SW_db[9]);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    pb_raw[0] = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    if (got !== '0) begin
      failures++; $display("FAIL midreset_clear got=%h exp=0", got);
    end
    checks++;
    tick(); tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (got !== exp_vec()) begin
        failures++; $display("FAIL midreset_model edge=%0d got=%h exp=%h", e, got, exp_vec());
      end
      checks++;
      if ((e == 5 && PB_press[0] !== 1'b0) || (e == 6 && PB_press[0] !== 1'b1)) begin
        failures++; $display("FAIL midreset_press edge=%0d press0=%b", e, PB_press[0]);
      end
      if (e == 5 || e == 6) checks++;
    end
    pb_raw[0] = 1'b0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_sticky();
    logic exp_set;
`ifdef NEXYS4_INPUT_STICKY_EN
    exp_set = 1'b1;
`else
    exp_set = 1'b0;
`endif
    pb_raw[4] = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    if (PB_sticky !== {exp_set, 4'b0000} || got !== exp_vec()) begin
      failures++; $display("FAIL sticky_set got=%b exp=%b", PB_sticky, {exp_set, 4'b0000});
    end
    checks++;
    pb_raw[4] = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    pb_raw[4] = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    if (PB_press[4] !== 1'b1) begin
      failures++; $display("FAIL sticky_press2 press4=%b exp=1", PB_press[4]);
    end
    checks++;
    pb_clr[4] = 1'b1;
    tick();
    pb_clr[4] = 1'b0;
    if (PB_sticky[4] !== exp_set || got !== exp_vec()) begin
      failures++; $display("FAIL sticky_setwins got=%b exp=%b", PB_sticky[4], exp_set);
    end
    checks++;
    tick();
    pb_clr[4] = 1'b1;
    tick();
    pb_clr[4] = 1'b0;
    if (PB_sticky[4] !== 1'b0 || got !== exp_vec()) begin
      failures++; $display("FAIL sticky_clear got=%b exp=0", PB_sticky[4]);
    end
    checks++;
    pb_raw[4] = 1'b0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N_SW; b++) if ($urandom_range(0, 99) < 8) sw_raw[b] = ~sw_raw[b];
      for (int b = 0; b < N_PB; b++) if ($urandom_range(0, 99) < 8) pb_raw[b] = ~pb_raw[b];
      for (int b = 0; b < N_PB; b++) pb_clr[b] = ($urandom_range(0, 9) == 0);
      if (c == 700) begin
        rst_n = 1'b0;
        model_reset();
      end
      if (c == 703) rst_n = 1'b1;
      tick();
      if (got !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, got, exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_sw_bounce();
    test_simultaneous();
    test_reset_mid();
    test_sticky();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
